// File: rtl/nm_pkg.sv
// nm_pkg: shared constants and types for the new-move line scanner.
//   - Board geometry and field widths.
//   - Cell colour codes, direction codes, command mode codes.
//   - Scanner FSM state encoding.
//   - Helpers: board address from (x, y); own/opponent colour for a player.
package nm_pkg;

    localparam int unsigned BOARD_DIM = 8;
    localparam int unsigned COORD_W   = 3;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned CELL_W    = 2;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned NUM_DIRS  = 4;

    localparam logic [CELL_W-1:0] CELL_EMPTY = 2'b00;
    localparam logic [CELL_W-1:0] CELL_BLACK = 2'b01;
    localparam logic [CELL_W-1:0] CELL_WHITE = 2'b10;

    localparam logic MODE_VALIDATE = 1'b0;
    localparam logic MODE_FLIP     = 1'b1;

    // Direction code doubles as the bit index into the per-direction status vector.
    typedef enum logic [1:0] {
        DIR_U = 2'd0,
        DIR_D = 2'd1,
        DIR_L = 2'd2,
        DIR_R = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StStep = 3'd1,
        StRd   = 3'd2,
        StEval = 3'd3,
        StWr   = 3'd4,
        StDone = 3'd5
    } scan_state_e;

    function automatic logic [ADDR_W-1:0] coord_addr(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(BOARD_DIM) + ADDR_W'(x);
    endfunction

    function automatic logic [CELL_W-1:0] own_cell(input logic player);
        return player ? CELL_WHITE : CELL_BLACK;
    endfunction

    function automatic logic [CELL_W-1:0] opp_cell(input logic player);
        return player ? CELL_BLACK : CELL_WHITE;
    endfunction

endpackage

// File: rtl/nm_coord_step.sv
// nm_coord_step: combinational one-square step on the board.
// Ports:
//   x, y       in   current coordinate
//   dir        in   step direction (U: y-1, D: y+1, L: x-1, R: x+1)
//   next_x/y   out  stepped coordinate (equals the input when off_board is set)
//   off_board  out  the step would leave the board
module nm_coord_step
    import nm_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  dir_e               dir,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y,
    output logic               off_board
);

    localparam logic [COORD_W-1:0] EDGE_MAX = COORD_W'(BOARD_DIM - 1);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

    always_comb begin
        next_x    = x;
        next_y    = y;
        off_board = 1'b0;
        unique case (dir)
            DIR_U: begin
                if (y == '0) off_board = 1'b1;
                else         next_y    = y - ONE;
            end
            DIR_D: begin
                if (y == EDGE_MAX) off_board = 1'b1;
                else               next_y    = y + ONE;
            end
            DIR_L: begin
                if (x == '0) off_board = 1'b1;
                else         next_x    = x - ONE;
            end
            DIR_R: begin
                if (x == EDGE_MAX) off_board = 1'b1;
                else               next_x    = x + ONE;
            end
            default: off_board = 1'b1;
        endcase
    end

endmodule

// File: rtl/nm_line_scanner.sv
// nm_line_scanner: walks board memory from a move origin in one direction per command.
//   VALIDATE: checks for a run of >=1 opponent discs closed by an own disc and records the
//             result in dir_status_o[dir].
//   FLIP:     rewrites each opponent disc on a previously validated line with the own colour.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_i, mode_i, dir_i     command pulse, mode (0 validate / 1 flip), direction
//   origin_x_i, origin_y_i     move origin
//   player_i                   0 black, 1 white
//   clear_i                    synchronous clear of dir_status_o
//   mem_addr_o, mem_rd_o       board read (data on mem_rdata_i one cycle later)
//   mem_rdata_i                board read data
//   mem_wr_o, mem_wdata_o      board write of the own colour
//   busy_o, s_done_o           command in progress / one-cycle completion pulse
//   dir_valid_o, dir_status_o  status bit of the latched direction / all directions
//   mv_valid_o                 any direction captures
module nm_line_scanner
    import nm_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                mode_i,
    input  logic [1:0]          dir_i,
    input  logic [COORD_W-1:0]  origin_x_i,
    input  logic [COORD_W-1:0]  origin_y_i,
    input  logic                player_i,
    input  logic                clear_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_rd_o,
    input  logic [CELL_W-1:0]   mem_rdata_i,
    output logic                mem_wr_o,
    output logic [CELL_W-1:0]   mem_wdata_o,
    output logic                busy_o,
    output logic                s_done_o,
    output logic                dir_valid_o,
    output logic [NUM_DIRS-1:0] dir_status_o,
    output logic                mv_valid_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BOARD_DIM - 2);

    scan_state_e state_q, state_d;

    // Command context, latched at start acceptance.
    logic               mode_q;
    dir_e               dir_q;
    logic               player_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;

    logic [CNT_W-1:0]    cnt_q;
    logic                valid_q;
    logic [NUM_DIRS-1:0] status_q, status_d;

    logic [COORD_W-1:0] step_x;
    logic [COORD_W-1:0] step_y;
    logic               step_off;

    logic               start_acc;
    logic               flip_skip;
    logic               rd_is_own;
    logic               rd_is_opp;

    nm_coord_step u_coord_step (
        .x         (x_q),
        .y         (y_q),
        .dir       (dir_q),
        .next_x    (step_x),
        .next_y    (step_y),
        .off_board (step_off)
    );

    assign start_acc = (state_q == StIdle) && start_i;
    // A flip on a direction that never validated has nothing to do.
    assign flip_skip = (mode_i == MODE_FLIP) && !status_q[dir_i];
    assign rd_is_own = (mem_rdata_i == own_cell(player_q));
    assign rd_is_opp = (mem_rdata_i == opp_cell(player_q));

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = flip_skip ? StDone : StStep;
            end
            StStep: state_d = step_off ? StDone : StRd;
            StRd:   state_d = StEval;
            StEval: begin
                if (rd_is_opp) state_d = (mode_q == MODE_FLIP) ? StWr : StStep;
                else           state_d = StDone;
            end
            StWr:   state_d = StStep;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        mem_wdata_o = CELL_EMPTY;
        busy_o      = 1'b1;
        s_done_o    = 1'b0;
        unique case (state_q)
            StIdle: busy_o   = 1'b0;
            StRd:   mem_rd_o = 1'b1;
            StWr: begin
                mem_wr_o    = 1'b1;
                mem_wdata_o = own_cell(player_q);
            end
            StDone: s_done_o = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr_o   = coord_addr(x_q, y_q);
    assign dir_status_o = status_q;
    assign dir_valid_o  = status_q[dir_q];
    assign mv_valid_o   = |status_q;

    // Clear first, then the completing VALIDATE writes its own bit on top.
    always_comb begin
        status_d = clear_i ? '0 : status_q;
        if ((state_q == StDone) && (mode_q == MODE_VALIDATE)) begin
            status_d[dir_q] = valid_q;
        end
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_VALIDATE;
            dir_q    <= DIR_U;
            player_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            status_q <= '0;
        end else begin
            status_q <= status_d;
            if (start_acc) begin
                mode_q   <= mode_i;
                dir_q    <= dir_e'(dir_i);
                player_q <= player_i;
                x_q      <= origin_x_i;
                y_q      <= origin_y_i;
                cnt_q    <= '0;
                valid_q  <= 1'b0;
            end
            if ((state_q == StStep) && !step_off) begin
                x_q <= step_x;
                y_q <= step_y;
            end
            if ((state_q == StEval) && (mode_q == MODE_VALIDATE)) begin
                if (rd_is_opp) begin
                    cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                end else if (rd_is_own) begin
                    valid_q <= (cnt_q != '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_nm_line_scanner.sv
// Self-checking bench for nm_line_scanner: directed scenarios plus randomized boards, all
// checked cycle by cycle against a line-walking model of the command rules.
module tb_nm_line_scanner;
    import nm_pkg::*;

    localparam int MAXC = 64;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start_i = 1'b0;
    logic                mode_i = 1'b0;
    logic [1:0]          dir_i = 2'd0;
    logic [COORD_W-1:0]  origin_x_i = '0;
    logic [COORD_W-1:0]  origin_y_i = '0;
    logic                player_i = 1'b0;
    logic                clear_i = 1'b0;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic                mem_rd_o;
    logic [CELL_W-1:0]   mem_rdata = '0;
    logic                mem_wr_o;
    logic [CELL_W-1:0]   mem_wdata_o;
    logic                busy_o;
    logic                s_done_o;
    logic                dir_valid_o;
    logic [NUM_DIRS-1:0] dir_status_o;
    logic                mv_valid_o;

    nm_line_scanner dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .dir_i        (dir_i),
        .origin_x_i   (origin_x_i),
        .origin_y_i   (origin_y_i),
        .player_i     (player_i),
        .clear_i      (clear_i),
        .mem_addr_o   (mem_addr_o),
        .mem_rd_o     (mem_rd_o),
        .mem_rdata_i  (mem_rdata),
        .mem_wr_o     (mem_wr_o),
        .mem_wdata_o  (mem_wdata_o),
        .busy_o       (busy_o),
        .s_done_o     (s_done_o),
        .dir_valid_o  (dir_valid_o),
        .dir_status_o (dir_status_o),
        .mv_valid_o   (mv_valid_o)
    );

    initial forever #5 clk = ~clk;

    // Board memory seen by the DUT; reloaded from init_board on load_req.
    logic [1:0] mem [64];
    logic [1:0] init_board [64];
    logic       load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_board[i];
        end else if (mem_wr_o) begin
            mem[mem_addr_o] <= mem_wdata_o;
        end
        if (mem_rd_o) mem_rdata <= mem[mem_addr_o];
    end

    // Model state and per-cycle expectations (cycle 1 = first cycle after acceptance).
    int   m_board [64];
    bit [3:0] m_status = 4'd0;
    bit   exp_rd [MAXC];
    bit   exp_wr [MAXC];
    int   exp_addr [MAXC];
    int   exp_len = 0;
    int   exp_own = 0;
    int   chk_dir = 0;

    int pin_done = -1, pin_rd = -1, pin_wr = -1, pin_first = -1, pin_last = -1, pin_status = -1;

    bit chk_on = 1'b0;
    bit rst_chk = 1'b0;
    bit rst_wr_req = 1'b0;
    bit rst_wr_seen = 1'b0;

    int cyc = 0, done_cyc = 0, rd_cnt = 0, wr_cnt = 0, wr_first = -1, wr_last = -1;
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Walk the line square by square and lay out what each cycle must show.
    task automatic build_expect(input bit mode, input int dir, input int ox, input int oy,
                                input bit player, input int clear_at);
        int x, y, nx, ny, a, c, opps, own, opp;
        bit fin, valid;
        for (int i = 0; i < MAXC; i++) begin
            exp_rd[i] = 1'b0;
            exp_wr[i] = 1'b0;
            exp_addr[i] = 0;
        end
        own = player ? 2 : 1;
        opp = player ? 1 : 2;
        exp_own = own;
        x = ox; y = oy; c = 1; opps = 0; fin = 1'b0; valid = 1'b0;
        if (mode && !m_status[dir]) begin
            exp_len = 1;
        end else begin
            while (!fin) begin
                nx = x; ny = y;
                case (dir)
                    0: ny = y - 1;
                    1: ny = y + 1;
                    2: nx = x - 1;
                    default: nx = x + 1;
                endcase
                if (nx < 0 || nx > 7 || ny < 0 || ny > 7) begin
                    c = c + 1;
                    fin = 1'b1;
                end else begin
                    x = nx; y = ny; a = y * 8 + x;
                    exp_rd[c + 1] = 1'b1;
                    exp_addr[c + 1] = a;
                    if (m_board[a] == opp) begin
                        opps++;
                        if (mode) begin
                            exp_wr[c + 3] = 1'b1;
                            exp_addr[c + 3] = a;
                            m_board[a] = own;
                            c = c + 4;
                        end else begin
                            c = c + 3;
                        end
                    end else begin
                        valid = (m_board[a] == own) && (opps >= 1);
                        c = c + 3;
                        fin = 1'b1;
                    end
                end
            end
            exp_len = c;
        end
        if (clear_at > 0) m_status = 4'd0;
        if (!mode) m_status[dir] = valid;
    endtask

    // Compare process.
    always @(negedge clk) begin
        int bad;
        if (rst_chk) begin
            chk("rst_busy", busy_o, 0);
            chk("rst_rd", mem_rd_o, 0);
            chk("rst_wr", mem_wr_o, 0);
            chk("rst_done", s_done_o, 0);
            chk("rst_status", dir_status_o, 0);
            chk("rst_mv_valid", mv_valid_o, 0);
            chk("rst_dir_valid", dir_valid_o, 0);
            chk("rst_addr", mem_addr_o, 0);
            if (rst_wr_req) chk("rst_hit_wr", rst_wr_seen, 1);
        end else if (chk_on) begin
            cyc++;
            if (cyc == 1) begin
                done_cyc = 0; rd_cnt = 0; wr_cnt = 0; wr_first = -1; wr_last = -1;
            end
            if (cyc < MAXC) begin
                chk("busy", busy_o, (cyc <= exp_len) ? 1 : 0);
                chk("done", s_done_o, (cyc == exp_len) ? 1 : 0);
                chk("rd", mem_rd_o, exp_rd[cyc]);
                chk("wr", mem_wr_o, exp_wr[cyc]);
                if (exp_rd[cyc] || exp_wr[cyc]) chk("addr", mem_addr_o, exp_addr[cyc]);
                if (exp_wr[cyc]) chk("wdata", mem_wdata_o, exp_own);
            end
            if (s_done_o && done_cyc == 0) done_cyc = cyc;
            if (mem_rd_o) rd_cnt++;
            if (mem_wr_o) begin
                wr_cnt++;
                if (wr_first < 0) wr_first = mem_addr_o;
                wr_last = mem_addr_o;
            end
            if (cyc == exp_len + 1) begin
                chk("dir_status", dir_status_o, m_status);
                chk("mv_valid", mv_valid_o, (m_status != 0) ? 1 : 0);
                chk("dir_valid", dir_valid_o, m_status[chk_dir]);
                bad = 0;
                for (int i = 0; i < 64; i++) if (int'(mem[i]) != m_board[i]) bad++;
                chk("board_cells_wrong", bad, 0);
                if (pin_done >= 0)   chk("pin_done_cycle", done_cyc, pin_done);
                if (pin_rd >= 0)     chk("pin_reads", rd_cnt, pin_rd);
                if (pin_wr >= 0)     chk("pin_writes", wr_cnt, pin_wr);
                if (pin_first >= 0)  chk("pin_first_wr_addr", wr_first, pin_first);
                if (pin_last >= 0)   chk("pin_last_wr_addr", wr_last, pin_last);
                if (pin_status >= 0) chk("pin_status", dir_status_o, pin_status);
            end
        end else begin
            cyc = 0;
        end
    end

    task automatic set_pins(input int d, input int r, input int w, input int f, input int l,
                            input int s);
        pin_done = d; pin_rd = r; pin_wr = w; pin_first = f; pin_last = l; pin_status = s;
    endtask

    task automatic clear_init();
        for (int i = 0; i < 64; i++) init_board[i] = 2'b00;
    endtask

    task automatic set_cell(input int x, input int y, input logic [1:0] v);
        init_board[y * 8 + x] = v;
    endtask

    task automatic load_board();
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
        for (int i = 0; i < 64; i++) m_board[i] = int'(init_board[i]);
    endtask

    task automatic run_cmd(input bit mode, input int dir, input int ox, input int oy,
                           input bit player, input int clear_req, input bit poke);
        int clear_at;
        clear_at = clear_req;
        build_expect(mode, dir, ox, oy, player, clear_req);
        if (clear_at > exp_len) clear_at = exp_len;
        chk_dir = dir;
        @(negedge clk);
        mode_i = mode;
        dir_i = 2'(dir);
        origin_x_i = 3'(ox);
        origin_y_i = 3'(oy);
        player_i = player;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        chk_on = 1'b1;
        for (int k = 1; k <= exp_len + 1; k++) begin
            clear_i = (k == clear_at);
            if (poke && k == 2 && exp_len >= 2) begin
                // Must be ignored: different everything, mid-command.
                start_i = 1'b1;
                mode_i = ~mode;
                dir_i = 2'(dir + 1);
                origin_x_i = 3'(ox + 3);
                origin_y_i = 3'(oy + 5);
                player_i = ~player;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chk_on = 1'b0;
        clear_i = 1'b0;
        start_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state.
        rst_n = 1'b0;
        rst_chk = 1'b1;
        clear_init();
        load_board();
        @(negedge clk);
        #1 rst_chk = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Empty board: single read of addr 28, empty ends the line.
        set_pins(4, 1, 0, -1, -1, 0);
        run_cmd(1'b0, 3, 3, 3, 1'b0, 0, 1'b0);

        // (4,3) white, (5,3) black, black to move: valid capture to the right.
        clear_init();
        set_cell(4, 3, 2'b10);
        set_cell(5, 3, 2'b01);
        load_board();
        set_pins(7, 2, 0, -1, -1, 8);
        run_cmd(1'b0, 3, 3, 3, 1'b0, 0, 1'b1);

        // Flip: STEP,RD,EVAL,WR for the flipped disc, then STEP,RD,EVAL,DONE -> cycle 8.
        set_pins(8, 2, 1, 28, 28, 8);
        run_cmd(1'b1, 3, 3, 3, 1'b0, 0, 1'b0);

        // Corner origin stepping off the board.
        set_pins(2, 0, 0, -1, -1, 8);
        run_cmd(1'b0, 0, 0, 0, 1'b0, 0, 1'b0);
        set_pins(1, 0, 0, -1, -1, 8);
        run_cmd(1'b1, 0, 0, 0, 1'b0, 0, 1'b1);

        // Longest capture: six white discs on row 7 closed by black at (7,7).
        clear_init();
        for (int x = 1; x <= 6; x++) set_cell(x, 7, 2'b10);
        set_cell(7, 7, 2'b01);
        load_board();
        set_pins(22, 7, 0, -1, -1, 8);
        run_cmd(1'b0, 3, 0, 7, 1'b0, 0, 1'b0);
        set_pins(28, 7, 6, 57, 62, 8);
        run_cmd(1'b1, 3, 0, 7, 1'b0, 0, 1'b0);

        // Clear in the DONE cycle: old bit 3 goes, the new bit 0 stays.
        clear_init();
        set_cell(3, 2, 2'b10);
        set_cell(3, 1, 2'b01);
        load_board();
        set_pins(7, 2, 0, -1, -1, 1);
        run_cmd(1'b0, 0, 3, 3, 1'b0, 7, 1'b0);

        // Reset in the middle of a flip's write cycle.
        clear_init();
        set_cell(4, 3, 2'b10);
        set_cell(5, 3, 2'b01);
        load_board();
        set_pins(-1, -1, -1, -1, -1, -1);
        run_cmd(1'b0, 3, 3, 3, 1'b0, 0, 1'b0);
        @(negedge clk);
        mode_i = 1'b1;
        dir_i = 2'd3;
        origin_x_i = 3'd3;
        origin_y_i = 3'd3;
        player_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        rst_wr_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (mem_wr_o) begin
                rst_wr_seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        #1;
        rst_n = 1'b0;
        rst_wr_req = 1'b1;
        rst_chk = 1'b1;
        m_status = 4'd0;
        @(negedge clk);
        #1 rst_chk = 1'b0;
        rst_wr_req = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        // The interrupted write must not have landed: the line is still capturable.
        set_pins(7, 2, 0, -1, -1, 8);
        run_cmd(1'b0, 3, 3, 3, 1'b0, 0, 1'b0);

        // Randomized boards.
        set_pins(-1, -1, -1, -1, -1, -1);
        for (int it = 0; it < 150; it++) begin
            int ox, oy, d, cl;
            bit pl;
            clear_init();
            for (int i = 0; i < 64; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                init_board[i] = (r < 2) ? 2'b00 : ((r < 6) ? 2'b01 : 2'b10);
            end
            load_board();
            ox = int'($urandom_range(0, 7));
            oy = int'($urandom_range(0, 7));
            d = int'($urandom_range(0, 3));
            pl = 1'($urandom_range(0, 1));
            cl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 30)) : 0;
            run_cmd(1'b0, d, ox, oy, pl, cl, 1'($urandom_range(0, 1)));
            run_cmd(1'b1, d, ox, oy, pl, 0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                run_cmd(1'b1, int'($urandom_range(0, 3)), ox, oy, pl, 0, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
